// File: rtl/crc32_pkg.sv
// Shared constants and helper functions for the IEEE 802.3 CRC-32 engine.
// The register form is non-reflected and non-inverted; data bit 0 enters first.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    // One byte through the MSB-first shift register, wire order d[0]..d[7].
    function automatic logic [31:0] crc32_next8(
        input logic [31:0] c,
        input logic [7:0]  d,
        input logic [31:0] poly = CRC32_POLY
    );
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? poly : 32'h0);
        end
        return r;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_next8_comb.sv
// Purely combinational one-byte CRC-32 next-state network.
// Kept separate so wider or narrower variants can chain or swap it.
module crc32_next8_comb
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY
) (
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    assign crc_out = crc32_next8(crc_in, d, POLY);

endmodule

// File: rtl/crc32_8023_engine.sv
// Byte-wide IEEE 802.3 CRC-32 engine: frame check on receive, FCS byte
// generation on transmit. One byte folded or shifted out per enabled clock.
module crc32_8023_engine
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY,
    parameter logic [31:0] INIT = CRC32_INIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  d,
    input  logic        load_init,
    input  logic        calc,
    input  logic        d_valid,
    output logic [31:0] crc_reg,
    output logic [7:0]  crc
);

    logic [31:0] crc_next;

    crc32_next8_comb #(
        .POLY (POLY)
    ) u_next8 (
        .crc_in  (crc_reg),
        .d       (d),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_reg <= INIT;
        end else if (load_init) begin
            crc_reg <= INIT;
        end else if (d_valid) begin
            if (calc) begin
                crc_reg <= crc_next;
            end else begin
                // Shift-out fills with ones so the register returns to INIT after four bytes.
                crc_reg <= {crc_reg[23:0], 8'hFF};
            end
        end
    end

    // Transmit order is LSB first, so the top byte is reversed and inverted.
    assign crc = bitrev8(~crc_reg[31:24]);

endmodule

// File: tb/tb_crc32_8023_engine.sv
// Self-checking bench for crc32_8023_engine against a reflected-domain CRC-32 model.
module tb_crc32_8023_engine;

    logic        clk;
    logic        reset;
    logic [7:0]  d;
    logic        load_init;
    logic        calc;
    logic        d_valid;
    logic [31:0] crc_reg;
    logic [7:0]  crc;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state kept in the reflected (LSB-first) domain of the standard CRC-32.
    logic [31:0] ref_s;

    logic [7:0] check_str [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                                  8'h36, 8'h37, 8'h38, 8'h39};

    crc32_8023_engine dut (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .load_init (load_init),
        .calc      (calc),
        .d_valid   (d_valid),
        .crc_reg   (crc_reg),
        .crc       (crc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    function automatic logic [31:0] ref_fold(input logic [31:0] s, input logic [7:0] b);
        logic [31:0] r;
        r = s ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Drive one clock of controls, update the model, then check both outputs.
    task automatic cyc(input logic r, input logic li, input logic cl,
                       input logic dv, input logic [7:0] db);
        reset = r; load_init = li; calc = cl; d_valid = dv; d = db;
        @(posedge clk);
        if (r || li)    ref_s = 32'hFFFFFFFF;
        else if (dv && cl) ref_s = ref_fold(ref_s, db);
        else if (dv)    ref_s = (ref_s >> 8) | 32'hFF000000;
        @(negedge clk);
        chk("reg_model", crc_reg, rev32(ref_s));
        chk("crc_model", {24'h0, crc}, {24'h0, ~ref_s[7:0]});
    endtask

    task automatic fold_check(input logic gaps);
        for (int i = 0; i < 9; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) cyc(0, 0, ($urandom_range(0, 1) == 1), 0, 8'($urandom));
            end
            cyc(0, 0, 1, 1, check_str[i]);
        end
    endtask

    logic [7:0] fcs_q [$];

    initial begin
        reset = 1'b1; load_init = 1'b0; calc = 1'b0; d_valid = 1'b0; d = 8'h00;
        ref_s = 32'hFFFFFFFF;
        @(negedge clk);

        cyc(1, 0, 1, 1, 8'hA5);
        cyc(1, 0, 1, 1, 8'h5A);
        chk("reset_reg", crc_reg, 32'hFFFFFFFF);
        chk("reset_crc", {24'h0, crc}, 32'h0);

        fold_check(0);
        chk("check_reg", crc_reg, 32'h9B63D02C);
        chk("check_crc", {24'h0, crc}, 32'h26);

        chk("shift0", {24'h0, crc}, 32'h26);
        cyc(0, 0, 0, 1, 8'h00);
        chk("shift1", {24'h0, crc}, 32'h39);
        cyc(0, 0, 0, 1, 8'h00);
        chk("shift2", {24'h0, crc}, 32'hF4);
        cyc(0, 0, 0, 1, 8'h00);
        chk("shift3", {24'h0, crc}, 32'hCB);
        cyc(0, 0, 0, 1, 8'h00);
        chk("shift_end_reg", crc_reg, 32'hFFFFFFFF);
        cyc(0, 0, 0, 1, 8'h00);
        chk("shift_extra_crc", {24'h0, crc}, 32'h0);

        cyc(0, 1, 0, 0, 8'h00);
        fold_check(0);
        cyc(0, 0, 1, 1, 8'h26);
        cyc(0, 0, 1, 1, 8'h39);
        cyc(0, 0, 1, 1, 8'hF4);
        cyc(0, 0, 1, 1, 8'hCB);
        chk("residue", crc_reg, 32'hC704DD7B);

        cyc(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 1, (i == 4) ? (check_str[i] ^ 8'h08) : check_str[i]);
        cyc(0, 0, 1, 1, 8'h26);
        cyc(0, 0, 1, 1, 8'h39);
        cyc(0, 0, 1, 1, 8'hF4);
        cyc(0, 0, 1, 1, 8'hCB);
        chk("residue_flip", {31'h0, crc_reg == 32'hC704DD7B}, 32'h0);

        cyc(0, 1, 1, 1, 8'h55);
        chk("load_prio", crc_reg, 32'hFFFFFFFF);

        fold_check(0);
        cyc(0, 0, 1, 0, 8'h77);
        cyc(0, 0, 1, 0, 8'h11);
        chk("hold", crc_reg, 32'h9B63D02C);

        cyc(0, 1, 0, 0, 8'h00);
        fold_check(1);
        chk("gaps", crc_reg, 32'h9B63D02C);

        cyc(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, check_str[i]);
        cyc(1, 0, 1, 1, 8'hEE);
        chk("mid_reset", crc_reg, 32'hFFFFFFFF);
        fold_check(0);
        chk("mid_reset_refold", crc_reg, 32'h9B63D02C);

        // Random frames closed with the model's own FCS must land on the residue.
        for (int f = 0; f < 20; f++) begin
            int len = $urandom_range(1, 40);
            cyc(0, 1, 0, 0, 8'h00);
            for (int i = 0; i < len; i++) cyc(0, 0, 1, 1, 8'($urandom));
            fcs_q.delete();
            for (int k = 0; k < 4; k++) fcs_q.push_back(~ref_s[8*k +: 8]);
            foreach (fcs_q[k]) cyc(0, 0, 1, 1, fcs_q[k]);
            chk("rand_residue", crc_reg, 32'hC704DD7B);
        end

        for (int i = 0; i < 2000; i++) begin
            logic [3:0] ctl;
            ctl = 4'($urandom);
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                ctl[0] | ctl[1], ctl[2] | ctl[3], 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
